// File: rtl/fft_loader_if.sv
// Sample-in / RAM-write-out bundle of the FFT input stage.
// master: upstream source plus FFT core; slave: fft_loader.
interface fft_loader_if #(
    parameter int width = 16,
    parameter int N_2   = 11
);
    logic                    sample_valid;
    logic signed [width-6:0] sample;
    logic                    sample_ready;
    logic                    fft_done;
    logic                    we;
    logic [N_2-1:0]          adr;
    logic [2*width-1:0]      wd;
    logic                    fft_start;
    logic                    busy;

    modport master (
        output sample_valid, sample, fft_done,
        input  sample_ready, we, adr, wd, fft_start, busy
    );

    modport slave (
        input  sample_valid, sample, fft_done,
        output sample_ready, we, adr, wd, fft_start, busy
    );
endinterface

// File: rtl/fft_loader.sv
// FFT input stage: Hann-windows one frame of real samples and writes them as
// complex words to the FFT RAM at bit-reversed addresses, then starts the FFT.
module hann_lut #(
    parameter int width = 16,
    parameter int N_2   = 11
) (
    input  logic             clk,
    input  logic             en,
    input  logic [N_2-1:0]   addr,
    output logic [width-1:0] coef
);
    localparam int unsigned N = 1 << N_2;

    // Coefficients are elaboration-time constants: round((2^width-1) * sin^2(pi*k/N)).
    function automatic logic [width-1:0] hann_coef(input int unsigned k);
        real pi;
        real scale;
        real c;
        pi    = 3.14159265358979323846;
        scale = real'((longint'(1) << width) - 1);
        c     = scale * 0.5 * (1.0 - $cos(2.0 * pi * real'(k) / real'(N)));
        return width'($rtoi(c + 0.5));
    endfunction

    logic [width-1:0] rom [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_rom
        assign rom[gi] = hann_coef(gi);
    end

    always_ff @(posedge clk) begin
        if (en) begin
            coef <= rom[addr];
        end
    end
endmodule

module fft_loader #(
    parameter int width = 16,
    parameter int N_2   = 11
) (
    input  logic         clk,
    input  logic         reset,
    fft_loader_if.slave  bus
);
    localparam int PW = 2 * width - 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DRAIN,
        START,
        WAIT_FFT
    } state_t;

    state_t         state, state_nx;
    logic [N_2-1:0] n, n_nx;
    logic           drain_cnt, drain_cnt_nx;
    logic           ready_q, start_q, busy_q;
    logic           hs;

    logic                    s1_valid;
    logic signed [width-6:0] s1_sample;
    logic [N_2-1:0]          s1_adr;
    logic [width-1:0]        coef;

    logic signed [PW-1:0]    prod;
    logic [width-1:0]        re;

    logic                    we_q;
    logic [N_2-1:0]          adr_q;
    logic [2*width-1:0]      wd_q;

    function automatic logic [N_2-1:0] bitrev(input logic [N_2-1:0] v);
        logic [N_2-1:0] r;
        for (int unsigned i = 0; i < N_2; i++) begin
            r[i] = v[N_2-1-i];
        end
        return r;
    endfunction

    assign hs = bus.sample_valid & ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            n         <= '0;
            drain_cnt <= 1'b0;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_nx;
            n         <= n_nx;
            drain_cnt <= drain_cnt_nx;
            // Outputs are registered from the next state so they line up with it.
            ready_q   <= (state_nx == LOAD);
            start_q   <= (state_nx == START);
            busy_q    <= (state_nx == DRAIN) || (state_nx == START) ||
                         (state_nx == WAIT_FFT) ||
                         ((state_nx == LOAD) && (n_nx != '0));
        end
    end

    always_comb begin
        state_nx     = state;
        n_nx         = n;
        drain_cnt_nx = drain_cnt;
        case (state)
            IDLE: state_nx = LOAD;
            LOAD: begin
                if (hs) begin
                    n_nx = n + 1'b1;
                    if (n == '1) begin
                        state_nx = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    drain_cnt_nx = 1'b0;
                    state_nx     = START;
                end else begin
                    drain_cnt_nx = 1'b1;
                end
            end
            START: state_nx = WAIT_FFT;
            WAIT_FFT: begin
                if (bus.fft_done) begin
                    state_nx = LOAD;
                    n_nx     = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    hann_lut #(
        .width (width),
        .N_2   (N_2)
    ) u_lut (
        .clk  (clk),
        .en   (hs),
        .addr (n),
        .coef (coef)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= hs;
        end
        if (hs) begin
            s1_sample <= bus.sample;
            s1_adr    <= bitrev(n);
        end
    end

    // Coefficient is unsigned, so it gets a zero sign bit before the signed multiply.
    always_comb begin
        prod = $signed(PW'(s1_sample)) * $signed(PW'($signed({1'b0, coef})));
        re   = width'(prod >>> width);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            we_q  <= 1'b0;
            adr_q <= '0;
            wd_q  <= '0;
        end else begin
            we_q <= s1_valid;
            if (s1_valid) begin
                adr_q <= s1_adr;
                wd_q  <= {re, {width{1'b0}}};
            end
        end
    end

    assign bus.sample_ready = ready_q;
    assign bus.fft_start    = start_q;
    assign bus.busy         = busy_q | hs;
    assign bus.we           = we_q;
    assign bus.adr          = adr_q;
    assign bus.wd           = wd_q;
endmodule

// File: tb/tb_fft_loader.sv
// Bench for fft_loader: scoreboard of windowed bit-reversed writes plus
// table vectors and hand-written hold-off / reset / repeat-frame sequences.
module tb_fft_loader;
    localparam int W  = 16;
    localparam int NB = 11;
    localparam int N  = 1 << NB;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fft_loader_if #(.width(W), .N_2(NB)) bus ();

    fft_loader #(.width(W), .N_2(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int unsigned bitrev(input int unsigned v);
        int unsigned r = 0;
        for (int i = 0; i < NB; i++) begin
            r = r | (((v >> i) & 1) << (NB - 1 - i));
        end
        return r;
    endfunction

    function automatic longint hann(input int unsigned k);
        real c;
        c = 65535.0 * 0.5 * (1.0 - $cos(2.0 * 3.14159265358979323846 * real'(k) / real'(N)));
        return longint'($rtoi(c + 0.5));
    endfunction

    function automatic logic [2*W-1:0] gold(input int unsigned k, input int s);
        longint p;
        longint re;
        logic [W-1:0] r16;
        p   = longint'(s) * hann(k);
        re  = p >>> W;
        r16 = re[W-1:0];
        return {r16, {W{1'b0}}};
    endfunction

    typedef struct {
        int unsigned  adr;
        logic [2*W-1:0] wd;
        longint       due;
    } wr_t;

    wr_t         sbq[$];
    longint      cyc = 0;
    int unsigned mn = 0;
    bit          start_armed = 0;
    longint      exp_start = 0;
    int          start_count = 0;
    int          frame_writes = 0;
    logic [2*W-1:0] mem [int unsigned];
    logic [2*W-1:0] ref_mem [int unsigned];
    int          fs [N];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.we) begin
            chk("write_expected", longint'(sbq.size() > 0), 1);
            if (sbq.size() > 0) begin
                wr_t e;
                e = sbq.pop_front();
                chk("write_cycle", cyc, e.due);
                chk("write_adr", longint'(bus.adr), longint'(e.adr));
                chk("write_wd", longint'(bus.wd), longint'(e.wd));
            end
            mem[int'(bus.adr)] = bus.wd;
            frame_writes++;
        end
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            chk("write_missing", cyc, sbq[0].due);
            void'(sbq.pop_front());
        end
        if (bus.fft_start) begin
            chk("start_armed", longint'(start_armed), 1);
            if (start_armed) chk("start_cycle", cyc, exp_start);
            start_armed = 0;
            start_count++;
        end
        if (reset) begin
            sbq.delete();
            mn = 0;
            start_armed = 0;
        end else if (bus.sample_valid && bus.sample_ready) begin
            wr_t e;
            e.adr = bitrev(mn);
            e.wd  = gold(mn, int'(bus.sample));
            e.due = cyc + 2;
            sbq.push_back(e);
            if (mn == N - 1) begin
                start_armed = 1;
                exp_start   = cyc + 3;
                mn = 0;
            end else begin
                mn++;
            end
        end
    end

    task automatic run_frame(input int start_idx, input int gap_pct, input int done_at,
                             input int reset_at, input bit hold, input int hold_sample,
                             input int done_delay);
        int idx = start_idx;
        int guard = 0;
        int sc0 = start_count;
        int hold_bad = 0;
        while (idx < N && guard < 8 * N) begin
            @(posedge clk); #1;
            bus.sample_valid = ($urandom_range(99) >= gap_pct);
            bus.sample       = (W-5)'(fs[idx]);
            bus.fft_done     = (idx == done_at);
            @(negedge clk);
            if (bus.sample_valid && bus.sample_ready) idx++;
            guard++;
            if (idx == reset_at) return;
        end
        chk("frame_accepted", idx, N);
        @(posedge clk); #1;
        bus.fft_done     = 1'b0;
        bus.sample_valid = hold;
        bus.sample       = (W-5)'(hold_sample);
        guard = 0;
        while (start_count == sc0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("start_seen", start_count - sc0, 1);
        chk("ready_in_wait", longint'(bus.sample_ready), 0);
        if (!hold) chk("busy_in_wait", longint'(bus.busy), 1);
        repeat (done_delay) begin
            @(negedge clk);
            if (bus.sample_ready) hold_bad++;
        end
        chk("holdoff_ready_cycles", hold_bad, 0);
        @(posedge clk); #1 bus.fft_done = 1'b1;
        @(posedge clk); #1 bus.fft_done = 1'b0;
        @(negedge clk);
        chk("ready_after_done", longint'(bus.sample_ready), 1);
        if (!hold) chk("busy_after_done", longint'(bus.busy), 0);
    endtask

    task automatic frame_counts(input string tag);
        chk({tag, "_writes"}, frame_writes, N);
        chk({tag, "_distinct_adr"}, mem.num(), N);
    endtask

    task automatic clear_frame();
        mem.delete();
        frame_writes = 0;
    endtask

    typedef struct {
        int          frame;
        int unsigned n;
        int          s;
        int unsigned adr;
        int          re;
    } vec_t;

    vec_t vecs [8];

    task automatic check_vecs(input int f);
        logic [2*W-1:0] w;
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].frame == f) begin
                chk("vec_adr_written", longint'(mem.exists(vecs[i].adr)), 1);
                w = mem.exists(vecs[i].adr) ? mem[vecs[i].adr] : '1;
                chk($sformatf("vec_re_n%0d_s%0d", vecs[i].n, vecs[i].s),
                    longint'($signed(w[2*W-1:W])), vecs[i].re);
                chk("vec_im", longint'(w[W-1:0]), 0);
            end
        end
    endtask

    task automatic random_fill();
        for (int i = 0; i < N; i++) fs[i] = int'($urandom_range(2047)) - 1024;
    endtask

    task automatic apply_vecs(input int f);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].frame == f) fs[vecs[i].n] = vecs[i].s;
        end
    endtask

    initial begin
        int diffs;
        int held;
        int sc0;
        vecs[0] = '{2, 1024,  1023,    1,  1022};
        vecs[1] = '{2,    0,  1023,    0,     0};
        vecs[2] = '{2,    1, -1024, 1024,     0};
        vecs[3] = '{2,    3,  1023, 1536,     0};
        vecs[4] = '{2, 2047, -1024, 2047,     0};
        vecs[5] = '{3, 1024, -1024,    1, -1024};
        vecs[6] = '{3,    3, -1024, 1536,    -1};
        vecs[7] = '{3,    1,  1023, 1024,     0};

        bus.sample_valid = 1'b0;
        bus.sample       = '0;
        bus.fft_done     = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_ready", longint'(bus.sample_ready), 0);
        chk("rst_we", longint'(bus.we), 0);
        chk("rst_adr", longint'(bus.adr), 0);
        chk("rst_wd", longint'(bus.wd), 0);
        chk("rst_start", longint'(bus.fft_start), 0);
        chk("rst_busy", longint'(bus.busy), 0);
        @(negedge clk);
        chk("ready_rise", longint'(bus.sample_ready), 1);
        chk("busy_idle_load", longint'(bus.busy), 0);

        // Frame 1: all-zero samples, back to back
        for (int i = 0; i < N; i++) fs[i] = 0;
        clear_frame();
        run_frame(0, 0, -1, -1, 0, 0, 10);
        frame_counts("f1");

        // Frame 2: table vectors, stray fft_done mid-LOAD
        random_fill();
        apply_vecs(2);
        clear_frame();
        run_frame(0, 0, 700, -1, 0, 0, 10);
        frame_counts("f2");
        check_vecs(2);
        ref_mem = mem;

        // Frame 3: identical input, compare against frame 2
        clear_frame();
        run_frame(0, 0, -1, -1, 0, 0, 10);
        frame_counts("f3");
        diffs = 0;
        for (int unsigned a = 0; a < N; a++) begin
            if (!mem.exists(a) || !ref_mem.exists(a) || mem[a] !== ref_mem[a]) diffs++;
        end
        chk("repeat_frame_diffs", diffs, 0);

        // Frame 4: ~50% gaps, sample_valid held high through WAIT_FFT
        random_fill();
        apply_vecs(3);
        held = int'($urandom_range(2047)) - 1024;
        clear_frame();
        run_frame(0, 50, -1, -1, 1, held, 15);
        frame_counts("f4");
        check_vecs(3);

        // Frame 5: held sample was index 0; reset after 500 handshakes
        random_fill();
        fs[0] = held;
        clear_frame();
        sc0 = start_count;
        run_frame(1, 0, -1, 500, 0, 0, 10);
        @(posedge clk); #1;
        bus.sample_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("inflight_write_before_reset", longint'(bus.we), 1);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("we_after_reset", longint'(bus.we), 0);
        chk("ready_after_reset", longint'(bus.sample_ready), 0);
        @(negedge clk);
        chk("ready_rise_after_reset", longint'(bus.sample_ready), 1);
        repeat (20) @(negedge clk);
        chk("no_start_after_reset", start_count - sc0, 0);

        // Frame 6: clean full frame after the aborted one
        random_fill();
        clear_frame();
        run_frame(0, 30, -1, -1, 0, 0, 10);
        frame_counts("f6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fft_loader.md
# fft_loader

Input stage of the FFT datapath. Accepts one frame of N = 2^N_2 real samples over a valid/ready handshake, applies the Hann window using the team's `hann_lut` ROM, and writes each windowed sample as a complex word into the FFT working RAM at its bit-reversed address. After the last write it pulses `fft_start`, then holds off new samples until the FFT reports `fft_done`, because the FFT owns the RAM during that time.

## Interface
- `width`, default 16: complex-word half width (real/imag bits each); must match the FFT core.
- `N_2`, default 11: log2 of frame length N.
- `clk`  in  1: single clock, all logic on rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `sample_valid`  in  1: `sample` holds a valid input this cycle.
- `sample`  in  width-5: signed real input sample (5 bits headroom for FFT growth).
- `sample_ready`  out  1: loader accepts `sample` this cycle if `sample_valid` is also high.
- `fft_done`  in  1: single-cycle pulse from the FFT core on completion.
- `we`  out  1: RAM write enable.
- `adr`  out  N_2: RAM write address, bit-reversed sample index.
- `wd`  out  2*width: write data {re, im}; im is always 0.
- `fft_start`  out  1: one-cycle pulse, frame fully loaded.
- `busy`  out  1: high from the first accepted sample until `fft_done`.

## Operation
- States: IDLE, LOAD, DRAIN, START, WAIT_FFT.
  - IDLE goes to LOAD unconditionally on the next cycle.
  - LOAD: `sample_ready` = 1. On each handshake (`sample_valid` & `sample_ready`), index n (N_2-bit counter) increments. Accepting n = N-1 moves to DRAIN.
  - DRAIN: waits 2 cycles for the pipeline to empty, then moves to START.
  - START: asserts `fft_start` for 1 cycle, then moves to WAIT_FFT.
  - WAIT_FFT: waits for `fft_done`, then goes to LOAD with n = 0.
- Window pipeline:
  - Stage 1 (cycle of acceptance): n drives the `hann_lut` address; `sample` and bitrev(n) are registered.
  - Stage 2: the ROM coefficient c is unsigned Q0.width, 0 to 2^width-1. Product p = sample × {0, c} (signed, (width-5)+(width+1) bits). Register re = p >>> width (arithmetic shift, truncates toward −inf), sign-extended to width bits, together with `adr` and `we` = 1.
- bitrev(n) reverses all N_2 bits; e.g. N_2 = 11: 1 → 1024, 3 → 1536, 2047 → 2047.
- `sample_valid` low in LOAD creates gaps. No write occurs for gap cycles, and the pipeline advances only on handshakes (each written word is tagged with its own index).
- `fft_done` outside WAIT_FFT is ignored.
- `sample_valid` outside LOAD is ignored. The sample is not consumed, and the upstream source must hold it.
- `busy` = 1 in LOAD when n ≠ 0 or a handshake occurs, and in DRAIN, START and WAIT_FFT. Otherwise 0.

## Timing
- Reset values (in effect the cycle after `reset` is sampled high):
  - state = IDLE, n = 0.
  - `we` = 0, `adr` = 0, `wd` = 0, `fft_start` = 0, `sample_ready` = 0, `busy` = 0.
  - Pipeline valid bits cleared.
- `sample_ready` rises 2 cycles after the `reset` deassertion edge (IDLE then LOAD). All outputs are registered.
- Latency: a handshake at cycle t produces a write at t+2 (`we` high for exactly that cycle).
- Maximum throughput is 1 sample/cycle, giving N consecutive `we` cycles.
- Last handshake (n = N-1) at t:
  - `sample_ready` is low from t+1.
  - The last write is at t+2.
  - `fft_start` is high at t+3 only.
- `fft_done` at cycle d: `sample_ready` = 1 and `busy` = 0 at d+1. A handshake is possible at d+1.
- Reset mid-frame or during WAIT_FFT:
  - The partial frame is discarded and in-flight writes are cancelled (`we` = 0 the next cycle).
  - No `fft_start` is issued, and reset-state behaviour applies.
- Exactly N writes and 1 `fft_start` occur per frame; no address is written twice per frame.

## Test plan
- Reset, then N back-to-back samples all = 0 → `sample_ready` high 2 cycles after reset release; N writes to addresses bitrev(0..N-1); `fft_start` pulse exactly 3 cycles after the last handshake.
- Window arithmetic (N_2 = 11, width = 16):
  - n = 1024 (c = 65535), sample = 1023 → write `adr` = 1, `wd` = {16'd1022, 16'd0}.
  - Same n, sample = −1024 → re = −1024.
  - n = 0 (c = 0), sample = 1023 → `wd` = 0 at `adr` 0.
- Random `sample_valid` gaps (~50% duty) → `we` count = N, each write 2 cycles after its handshake, addresses and data match a golden model (bitrev + Hann, truncating shift).
- Hold-off: `sample_valid` held high after the frame → no handshakes until the cycle after a `fft_done` pulse. A `fft_done` injected during LOAD → no effect on state or n.
- Reset asserted after 500 handshakes with 2 writes in flight → `we` = 0 from the next cycle, no `fft_start`. A following full frame loads cleanly from n = 0.
- Two consecutive frames with `fft_done` 10 cycles after `fft_start` → second frame's writes identical in addresses and data to the first for identical input.
